// File: rtl/crc_frame_ctrl.sv
// Frame sequencer for the 8-bit serial CRC shift register: buffers a byte frame,
// streams it LSB-first without gaps, then collects the serial CRC into a byte.
// Optional drain watchdog enabled by defining CRC_DRAIN_TIMEOUT_EN.
module crc_frame_ctrl #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       lfsr_data,
    output logic       lfsr_active,
    output logic       lfsr_rst_n,
    input  logic       lfsr_crc,
    input  logic       lfsr_valid,
    output logic [7:0] crc_out,
    output logic       crc_valid,
    output logic       busy,
    output logic       err
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [2:0]      cap_cnt_q, cap_cnt_d;
    logic [7:0]      crc_shift_q, crc_shift_d;
    logic [7:0]      crc_out_q, crc_out_d;
    logic            crc_valid_q, crc_valid_d;
    logic            err_q, err_d;
    logic            live_q;

    logic            accept;
    logic            overflow;
    logic            last_bit;
    logic            capture_last;
    logic            timeout;
    logic            clear;

    assign accept       = in_ready && in_valid;
    assign overflow     = accept && !in_last && (cnt_q == LAST_CNT);
    assign last_bit     = (bit_idx_q == 3'd7) && ({1'b0, rd_ptr_q} == cnt_q - (AW+1)'(1));
    assign capture_last = (state_q == DRAIN) && lfsr_valid && (cap_cnt_q == 3'd7);
    assign clear        = (state_q == DONE) || timeout;

`ifdef CRC_DRAIN_TIMEOUT_EN
    // Counts consecutive DRAIN cycles without a capture; held at zero elsewhere.
    logic [2:0] wd_q, wd_d;

    always_comb begin
        wd_d = wd_q;
        if (state_q != DRAIN || lfsr_valid) wd_d = '0;
        else                                wd_d = wd_q + 3'd1;
    end

    assign timeout = (state_q == DRAIN) && !lfsr_valid && (wd_q == 3'd3);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) wd_q <= '0;
        else     wd_q <= wd_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && in_last) state_d = CLEAR;
            CLEAR:   state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DRAIN;
            DRAIN: begin
                if (capture_last) state_d = DONE;
                else if (timeout) state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // live_q keeps handshake and shift-register reset low until the first edge after RST.
    always_comb begin
        in_ready    = 1'b0;
        lfsr_active = 1'b0;
        lfsr_data   = 1'b0;
        lfsr_rst_n  = 1'b0;
        busy        = (state_q != IDLE) || (cnt_q != '0);
        case (state_q)
            IDLE:  begin
                in_ready   = live_q;
                lfsr_rst_n = live_q;
            end
            CLEAR: lfsr_rst_n = 1'b0;
            SHIFT: begin
                lfsr_rst_n  = 1'b1;
                lfsr_active = 1'b1;
                lfsr_data   = mem_q[rd_ptr_q][bit_idx_q];
            end
            default: lfsr_rst_n = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        cap_cnt_d   = cap_cnt_q;
        crc_shift_d = crc_shift_q;
        crc_out_d   = crc_out_q;
        crc_valid_d = (state_q == DONE);
        err_d       = overflow || timeout;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (overflow) begin
                        wr_ptr_d = '0;
                        cnt_d    = '0;
                    end else begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        cnt_d    = cnt_q + (AW+1)'(1);
                    end
                end
            end
            SHIFT: begin
                bit_idx_d = bit_idx_q + 3'd1;
                if (bit_idx_q == 3'd7) rd_ptr_d = rd_ptr_q + AW'(1);
            end
            DRAIN: begin
                if (lfsr_valid) begin
                    crc_shift_d[cap_cnt_q] = lfsr_crc;
                    cap_cnt_d              = cap_cnt_q + 3'd1;
                end
            end
            DONE:    crc_out_d = crc_shift_q;
            default: ;
        endcase
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            cnt_d       = '0;
            bit_idx_d   = '0;
            cap_cnt_d   = '0;
            crc_shift_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            cap_cnt_q   <= '0;
            crc_shift_q <= '0;
            crc_out_q   <= '0;
            crc_valid_q <= 1'b0;
            err_q       <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            cap_cnt_q   <= cap_cnt_d;
            crc_shift_q <= crc_shift_d;
            crc_out_q   <= crc_out_d;
            crc_valid_q <= crc_valid_d;
            err_q       <= err_d;
            live_q      <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) mem_q[wr_ptr_q] <= in_data;
    end

    assign crc_out   = crc_out_q;
    assign crc_valid = crc_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Directed bench for crc_frame_ctrl paired with a behavioural model of the team's
// serial CRC-8 (poly 0x07) shift register; honours CRC_DRAIN_TIMEOUT_EN.
module tb_crc_frame_ctrl;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready, lfsr_data, lfsr_active, lfsr_rst_n;
    logic       lfsr_crc, lfsr_valid;
    logic [7:0] crc_out;
    logic       crc_valid, busy, err;

    crc_frame_ctrl #(.DEPTH(16)) dut (
        .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .lfsr_data(lfsr_data), .lfsr_active(lfsr_active),
        .lfsr_rst_n(lfsr_rst_n), .lfsr_crc(lfsr_crc), .lfsr_valid(lfsr_valid),
        .crc_out(crc_out), .crc_valid(crc_valid), .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    // Shift register model: absorbs bits while Active, then emits 8 CRC bits MSB first.
    logic       stub_valid = 1'b0;
    logic [7:0] m_crc;
    logic       m_pend, m_valid, m_out;
    int         m_cnt;

    always @(posedge CLK) begin
        if (!lfsr_rst_n) begin
            m_crc <= 8'h00; m_pend <= 1'b0; m_cnt <= 0; m_valid <= 1'b0; m_out <= 1'b0;
        end else if (lfsr_active) begin
            m_crc   <= {m_crc[6:0], 1'b0} ^ ((m_crc[7] ^ lfsr_data) ? 8'h07 : 8'h00);
            m_pend  <= 1'b1;
            m_cnt   <= 0;
            m_valid <= 1'b0;
        end else if (m_pend && m_cnt < 8) begin
            m_valid <= 1'b1;
            m_out   <= m_crc[7];
            m_crc   <= {m_crc[6:0], 1'b0};
            m_cnt   <= m_cnt + 1;
        end else begin
            m_valid <= 1'b0;
            m_pend  <= 1'b0;
        end
    end

    assign lfsr_crc   = m_out;
    assign lfsr_valid = stub_valid ? 1'b0 : m_valid;

    int   cyc = 0;
    int   act_cnt = 0, act_runs = 0, act_last = 0, rstn_low = 0;
    int   err_cnt = 0, err_cyc = 0, cv_cnt = 0, cv_cyc = 0;
    logic act_prev = 1'b0;
    logic bits_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (!RST) begin
            if (lfsr_active) begin
                act_cnt++;
                act_last = cyc;
                bits_q.push_back(lfsr_data);
                if (!act_prev) act_runs++;
            end
            act_prev = lfsr_active;
            if (!lfsr_rst_n) rstn_low++;
            if (err) begin err_cnt++; err_cyc = cyc; end
            if (crc_valid) begin cv_cnt++; cv_cyc = cyc; end
        end else begin
            act_prev = 1'b0;
        end
    end

    int         n_assert = 0, n_fail = 0;
    int         acc_cyc = 0;
    int         b_act, b_runs, b_rstn, b_err, b_cv, b_bits;
    logic [7:0] cur_frame[$];
    logic [7:0] crc_keep;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic snap();
        b_act = act_cnt; b_runs = act_runs; b_rstn = rstn_low;
        b_err = err_cnt; b_cv = cv_cnt; b_bits = bits_q.size();
        cur_frame.delete();
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        int t = 0;
        in_data = d; in_valid = 1'b1; in_last = last;
        while (in_ready !== 1'b1 && t < 200) begin tick(1); t++; end
        if (t >= 200) check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        tick(1);
        acc_cyc  = cyc;
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        cur_frame.push_back(d);
    endtask

    task automatic wait_cv();
        int t = 0;
        while (cv_cnt == b_cv && t < 1000) begin tick(1); t++; end
        check("crc_valid_seen", cv_cnt - b_cv, 1);
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_in_ready"}, {31'd0, in_ready}, 0);
        check({p, "_lfsr_active"}, {31'd0, lfsr_active}, 0);
        check({p, "_lfsr_data"}, {31'd0, lfsr_data}, 0);
        check({p, "_lfsr_rst_n"}, {31'd0, lfsr_rst_n}, 0);
        check({p, "_crc_out"}, {24'd0, crc_out}, 32'h00);
        check({p, "_crc_valid"}, {31'd0, crc_valid}, 0);
        check({p, "_busy"}, {31'd0, busy}, 0);
        check({p, "_err"}, {31'd0, err}, 0);
    endtask

    function automatic logic [31:0] get_bits(input int base, input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v[i] = bits_q[base + i];
        return v;
    endfunction

    function automatic logic [7:0] crc_ref(input logic [7:0] f[$]);
        logic [7:0] c;
        logic [7:0] r;
        c = 8'h00;
        foreach (f[k])
            for (int b = 0; b < 8; b++)
                c = {c[6:0], 1'b0} ^ ((c[7] ^ f[k][b]) ? 8'h07 : 8'h00);
        for (int i = 0; i < 8; i++) r[i] = c[7 - i];
        return r;
    endfunction

    initial begin
        // Reset state
        #12;
        check_reset_vals("por");
        tick(1);
        RST = 1'b0;
        tick(2);
        check("idle_in_ready", {31'd0, in_ready}, 1);
        check("idle_lfsr_rst_n", {31'd0, lfsr_rst_n}, 1);

        // One-byte frame 0xA5
        snap();
        send(8'hA5, 1'b1);
        check("a5_busy", {31'd0, busy}, 1);
        check("a5_in_ready_low", {31'd0, in_ready}, 0);
        wait_cv();
        check("a5_latency", cv_cyc - acc_cyc, 19);
        check("a5_crc_out", {24'd0, crc_out}, 32'h4E);
        check("a5_active_cycles", act_cnt - b_act, 8);
        check("a5_data_bits", get_bits(b_bits, 8), 32'hA5);
        check("a5_rstn_low_cycles", rstn_low - b_rstn, 1);
        check("a5_in_ready_back", {31'd0, in_ready}, 1);
        tick(1);
        check("a5_crc_valid_pulse", {31'd0, crc_valid}, 0);
        check("a5_crc_out_hold", {24'd0, crc_out}, 32'h4E);
        check("a5_busy_idle", {31'd0, busy}, 0);

        // Three-byte frame with gaps between bytes
        snap();
        send(8'h01, 1'b0);
        tick(2);
        check("gap_no_active", {31'd0, lfsr_active}, 0);
        send(8'h02, 1'b0);
        tick(3);
        send(8'h80, 1'b1);
        wait_cv();
        check("f3_latency", cv_cyc - acc_cyc, 35);
        check("f3_active_cycles", act_cnt - b_act, 24);
        check("f3_active_runs", act_runs - b_runs, 1);
        check("f3_data_bits", get_bits(b_bits, 24), 32'h00800201);
        check("f3_crc_out", {24'd0, crc_out}, {24'd0, crc_ref(cur_frame)});
        check("f3_err", err_cnt - b_err, 0);

        // Overflow: 16 bytes without in_last
        snap();
        for (int i = 0; i < 16; i++) begin
            send(8'(i * 13 + 7), 1'b0);
            if (i == 0) check("ovf_busy_first", {31'd0, busy}, 1);
        end
        check("ovf_err_timing", err_cyc, acc_cyc);
        tick(2);
        check("ovf_err_count", err_cnt - b_err, 1);
        check("ovf_no_active", act_cnt - b_act, 0);
        check("ovf_in_ready", {31'd0, in_ready}, 1);
        check("ovf_busy_cleared", {31'd0, busy}, 0);
        check("ovf_no_crc_valid", cv_cnt - b_cv, 0);
        snap();
        send(8'h3C, 1'b1);
        wait_cv();
        check("post_ovf_latency", cv_cyc - acc_cyc, 19);
        check("post_ovf_crc", {24'd0, crc_out}, {24'd0, crc_ref(cur_frame)});

        // Full 16-byte frame, in_last on the 16th byte
        snap();
        for (int i = 0; i < 16; i++) send(8'(8'h5A ^ (i * 8'h11)), i == 15);
        wait_cv();
        check("full_latency", cv_cyc - acc_cyc, 139);
        check("full_active_cycles", act_cnt - b_act, 128);
        check("full_err", err_cnt - b_err, 0);
        check("full_crc", {24'd0, crc_out}, {24'd0, crc_ref(cur_frame)});
        tick(2);

        // Reset pulsed during SHIFT
        snap();
        send(8'hFF, 1'b1);
        tick(4);
        check("rst_in_shift", {31'd0, lfsr_active}, 1);
        RST = 1'b1;
        #1;
        check_reset_vals("midrst");
        tick(3);
        check("midrst_rstn_held", {31'd0, lfsr_rst_n}, 0);
        RST = 1'b0;
        tick(40);
        check("midrst_no_crc_valid", cv_cnt - b_cv, 0);
        check("midrst_no_err", err_cnt - b_err, 0);
        snap();
        send(8'h00, 1'b1);
        wait_cv();
        check("midrst_zero_latency", cv_cyc - acc_cyc, 19);
        check("midrst_zero_crc", {24'd0, crc_out}, 32'h00);

        // Shift register Valid stuck low during DRAIN
        tick(2);
        crc_keep = crc_out;
        snap();
        stub_valid = 1'b1;
        send(8'hC3, 1'b1);
        tick(12);
`ifdef CRC_DRAIN_TIMEOUT_EN
        begin
            int t = 0;
            while (err_cnt == b_err && t < 100) begin tick(1); t++; end
        end
        check("wd_err_count", err_cnt - b_err, 1);
        check("wd_err_timing", err_cyc - (act_last + 1), 4);
        tick(2);
        check("wd_no_crc_valid", cv_cnt - b_cv, 0);
        check("wd_crc_out_kept", {24'd0, crc_out}, {24'd0, crc_keep});
        check("wd_idle", {31'd0, busy}, 0);
`else
        tick(60);
        check("stuck_busy", {31'd0, busy}, 1);
        check("stuck_no_err", err_cnt - b_err, 0);
        check("stuck_no_crc_valid", cv_cnt - b_cv, 0);
        check("stuck_in_ready_low", {31'd0, in_ready}, 0);
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(2);
`endif
        stub_valid = 1'b0;
        tick(2);
        snap();
        send(8'hA5, 1'b1);
        wait_cv();
        check("recover_crc", {24'd0, crc_out}, 32'h4E);
        check("recover_latency", cv_cyc - acc_cyc, 19);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
